// File: rtl/traffic_tick_ctrl_pkg.sv
// Shared definitions for the traffic_fsm control stage: state encoding and default timing.
package traffic_tick_ctrl_pkg;

  // 2'd3 is unused and decodes back to StIdle.
  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRun   = 2'd1,
    StPause = 2'd2
  } state_e;

  // 1 s tick and 10 ms debounce at a 100 MHz clock.
  localparam int unsigned TickDivDefault  = 100_000_000;
  localparam int unsigned DbCyclesDefault = 1_000_000;

endpackage

// File: rtl/debounce_sync.sv
// Two-flop synchroniser followed by a counting debouncer and a registered rising-edge detector.
module debounce_sync #(
  parameter int unsigned DB_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_raw,
  output logic o_level,
  output logic o_rise
);

  localparam int unsigned CntW = $clog2(DB_CYCLES + 1);

  logic            sync1_q, sync2_q;
  logic            level_q, level_d;
  logic            level_dly_q;
  logic [CntW-1:0] cnt_q, cnt_d;

  // Count consecutive cycles of disagreement; flip the stable level when the count completes.
  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    if (sync2_q != level_q) begin
      if (cnt_q == CntW'(DB_CYCLES - 1)) begin
        level_d = ~level_q;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Synchroniser, debounce counter, stable level and its one-cycle-delayed copy.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      cnt_q       <= '0;
      level_q     <= 1'b0;
      level_dly_q <= 1'b0;
    end else begin
      sync1_q     <= i_raw;
      sync2_q     <= sync1_q;
      cnt_q       <= cnt_d;
      level_q     <= level_d;
      level_dly_q <= level_q;
    end
  end

  assign o_level = level_q;
  // Both terms are registers, so a press is exactly one cycle wide and never retriggers.
  assign o_rise  = level_q & ~level_dly_q;

endmodule

// File: rtl/traffic_tick_ctrl.sv
// Run/pause/clear control for traffic_fsm: conditions the board inputs, runs the tick prescaler
// and drives a registered tick enable, frozen mode flag and local FSM reset.
module traffic_tick_ctrl
  import traffic_tick_ctrl_pkg::*;
#(
  parameter int unsigned TICK_DIV  = TickDivDefault,
  parameter int unsigned DB_CYCLES = DbCyclesDefault
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_btn_run,
  input  logic i_btn_clr,
  input  logic i_sw_mode,
  output logic o_start,
  output logic o_flag,
  output logic o_fsm_rst_n,
  output logic o_running
);

  localparam int unsigned PrescW = $clog2(TICK_DIV);
  localparam logic [PrescW-1:0] PrescLast = PrescW'(TICK_DIV - 1);

  logic run_rise, clr_rise, mode_level;
  logic unused_run_level, unused_clr_level, unused_mode_rise;

  state_e            state_q, state_d;
  logic [PrescW-1:0] presc_q, presc_d;
  logic              start_q, start_d;
  logic              flag_q, flag_d;
  logic              fsm_rst_n_q, fsm_rst_n_d;
  logic              running_q, running_d;

  debounce_sync #(.DB_CYCLES(DB_CYCLES)) u_db_run (
    .clk     (clk),
    .reset_n (reset_n),
    .i_raw   (i_btn_run),
    .o_level (unused_run_level),
    .o_rise  (run_rise)
  );

  debounce_sync #(.DB_CYCLES(DB_CYCLES)) u_db_clr (
    .clk     (clk),
    .reset_n (reset_n),
    .i_raw   (i_btn_clr),
    .o_level (unused_clr_level),
    .o_rise  (clr_rise)
  );

  debounce_sync #(.DB_CYCLES(DB_CYCLES)) u_db_mode (
    .clk     (clk),
    .reset_n (reset_n),
    .i_raw   (i_sw_mode),
    .o_level (mode_level),
    .o_rise  (unused_mode_rise)
  );

  // Next state on press pulses; clear overrides a simultaneous run press.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (run_rise) state_d = StRun;
      StRun:   if (run_rise) state_d = StPause;
      StPause: if (run_rise) state_d = StRun;
      default: state_d = StIdle;
    endcase
    if (clr_rise) begin
      state_d = StIdle;
    end
  end

  // Prescaler: zero in IDLE, counts in RUN, holds in PAUSE.
  always_comb begin
    presc_d = presc_q;
    if (state_d == StIdle) begin
      presc_d = '0;
    end else if (state_q == StRun) begin
      presc_d = (presc_q == PrescLast) ? '0 : presc_q + 1'b1;
    end else if (state_q != StPause) begin
      // Entering RUN from IDLE: preload the last count so the first RUN cycle carries a tick
      // and the following ones land every TICK_DIV cycles.
      presc_d = PrescLast;
    end
  end

  // Registered outputs mirror the current state one edge later.
  always_comb begin
    start_d     = (state_q == StRun) && (presc_q == PrescLast);
    running_d   = (state_q == StRun);
    fsm_rst_n_d = (state_q == StRun) || (state_q == StPause);
    flag_d      = (state_q == StIdle) ? mode_level : flag_q;
  end

  // State, prescaler and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      presc_q     <= '0;
      start_q     <= 1'b0;
      flag_q      <= 1'b0;
      fsm_rst_n_q <= 1'b0;
      running_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      presc_q     <= presc_d;
      start_q     <= start_d;
      flag_q      <= flag_d;
      fsm_rst_n_q <= fsm_rst_n_d;
      running_q   <= running_d;
    end
  end

  assign o_start     = start_q;
  assign o_flag      = flag_q;
  assign o_fsm_rst_n = fsm_rst_n_q;
  assign o_running   = running_q;

endmodule

// File: tb/tb_traffic_tick_ctrl.sv
// Self-checking bench for traffic_tick_ctrl with TICK_DIV=4, DB_CYCLES=3.
// Output vectors are {o_start, o_flag, o_fsm_rst_n, o_running}. A raw input driven just after
// edge t changes the state at edge t+6; the registered outputs show it after edge t+7.
module tb_traffic_tick_ctrl;

  logic clk = 1'b0;
  logic reset_n, btn_run, btn_clr, sw_mode;
  logic o_start, o_flag, o_fsm_rst_n, o_running;

  int total = 0;
  int bad   = 0;
  logic [3:0] exp_q[$];

  always #5 clk = ~clk;

  traffic_tick_ctrl #(
    .TICK_DIV  (4),
    .DB_CYCLES (3)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .i_btn_run   (btn_run),
    .i_btn_clr   (btn_clr),
    .i_sw_mode   (sw_mode),
    .o_start     (o_start),
    .o_flag      (o_flag),
    .o_fsm_rst_n (o_fsm_rst_n),
    .o_running   (o_running)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench just after an edge with reset released: this is t=0 of every scenario.
  task automatic do_reset();
    reset_n = 1'b0;
    btn_run = 1'b0;
    btn_clr = 1'b0;
    sw_mode = 1'b0;
    repeat (3) cyc();
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [3:0] want, obs;
    reset_n = 1'b0;
    for (int i = 0; i < 5; i++) begin
      btn_run = i[0];
      btn_clr = ~i[0];
      sw_mode = i[0];
      exp_q.push_back(4'b0000);
      cyc();
      want = exp_q.pop_front();
      obs  = {o_start, o_flag, o_fsm_rst_n, o_running};
      total++;
      if (obs !== want) begin
        bad++;
        $display("FAIL reset_hold cycle %0d: got %b want %b", i, obs, want);
      end
    end
    reset_n = 1'b1;
    btn_run = 1'b0;
    btn_clr = 1'b0;
    sw_mode = 1'b0;
    for (int i = 0; i < 10; i++) begin
      exp_q.push_back(4'b0000);
      cyc();
      want = exp_q.pop_front();
      obs  = {o_start, o_flag, o_fsm_rst_n, o_running};
      total++;
      if (obs !== want) begin
        bad++;
        $display("FAIL reset_release cycle %0d: got %b want %b", i, obs, want);
      end
    end
  endtask

  // 2-cycle glitch is rejected; a 10-cycle hold gives one RUN entry (state at edge 18).
  task automatic test_debounce();
    logic [3:0] want, obs;
    int e;
    do_reset();
    for (int t = 0; t < 32; t++) begin
      e = t + 1;
      case (t)
        0:  btn_run = 1'b1;
        2:  btn_run = 1'b0;
        12: btn_run = 1'b1;
        22: btn_run = 1'b0;
        default: ;
      endcase
      if (e < 19) exp_q.push_back(4'b0000);
      else        exp_q.push_back({((e - 19) % 4) == 0, 1'b0, 1'b1, 1'b1});
      cyc();
      want = exp_q.pop_front();
      obs  = {o_start, o_flag, o_fsm_rst_n, o_running};
      total++;
      if (obs !== want) begin
        bad++;
        $display("FAIL debounce edge %0d: got %b want %b", e, obs, want);
      end
    end
  endtask

  // Run held continuously: tick in the first RUN cycle then every 4th; 21 RUN cycles -> 6 ticks.
  task automatic test_tick_cadence();
    logic [3:0] want, obs;
    int e;
    int pulses = 0;
    do_reset();
    btn_run = 1'b1;
    for (int t = 0; t < 27; t++) begin
      e = t + 1;
      if (e < 7) exp_q.push_back(4'b0000);
      else       exp_q.push_back({((e - 7) % 4) == 0, 1'b0, 1'b1, 1'b1});
      cyc();
      if (o_start === 1'b1) pulses++;
      want = exp_q.pop_front();
      obs  = {o_start, o_flag, o_fsm_rst_n, o_running};
      total++;
      if (obs !== want) begin
        bad++;
        $display("FAIL tick_cadence edge %0d: got %b want %b", e, obs, want);
      end
    end
    total++;
    if (pulses !== 6) begin
      bad++;
      $display("FAIL tick_count: got %0d pulses want 6", pulses);
    end
    btn_run = 1'b0;
  endtask

  // Pause 2 cycles after the tick at edge 15; resume at edge 28; next tick at edge 30.
  task automatic test_pause_resume();
    logic [3:0] want, obs;
    int e;
    do_reset();
    for (int t = 0; t < 34; t++) begin
      e = t + 1;
      case (t)
        0, 11, 22: btn_run = 1'b1;
        4, 15, 26: btn_run = 1'b0;
        default: ;
      endcase
      if (e <= 6)       exp_q.push_back(4'b0000);
      else if (e <= 17) exp_q.push_back({((e - 7) % 4) == 0, 1'b0, 1'b1, 1'b1});
      else if (e <= 28) exp_q.push_back(4'b0010);
      else              exp_q.push_back({(e == 30) || (e == 34), 1'b0, 1'b1, 1'b1});
      cyc();
      want = exp_q.pop_front();
      obs  = {o_start, o_flag, o_fsm_rst_n, o_running};
      total++;
      if (obs !== want) begin
        bad++;
        $display("FAIL pause_resume edge %0d: got %b want %b", e, obs, want);
      end
    end
  endtask

  // Mode latched in IDLE, frozen through RUN despite the switch flipping, relatched after clear.
  task automatic test_mode_latch();
    logic [3:0] want, obs;
    int e;
    do_reset();
    for (int t = 0; t < 34; t++) begin
      e = t + 1;
      case (t)
        0:  sw_mode = 1'b1;
        8:  btn_run = 1'b1;
        12: btn_run = 1'b0;
        16: sw_mode = 1'b0;
        24: btn_clr = 1'b1;
        28: btn_clr = 1'b0;
        default: ;
      endcase
      if (e <= 5)       exp_q.push_back(4'b0000);
      else if (e <= 14) exp_q.push_back(4'b0100);
      else if (e <= 30) exp_q.push_back({((e - 15) % 4) == 0, 1'b1, 1'b1, 1'b1});
      else              exp_q.push_back(4'b0000);
      cyc();
      want = exp_q.pop_front();
      obs  = {o_start, o_flag, o_fsm_rst_n, o_running};
      total++;
      if (obs !== want) begin
        bad++;
        $display("FAIL mode_latch edge %0d: got %b want %b", e, obs, want);
      end
    end
  endtask

  // Aligned clr+run presses in RUN -> IDLE; later reset_n=0 mid-RUN suppresses the due tick.
  task automatic test_priority();
    logic [3:0] want, obs;
    int e;
    do_reset();
    for (int t = 0; t < 31; t++) begin
      e = t + 1;
      case (t)
        0, 20: btn_run = 1'b1;
        4, 24: btn_run = 1'b0;
        10: begin btn_run = 1'b1; btn_clr = 1'b1; end
        14: begin btn_run = 1'b0; btn_clr = 1'b0; end
        30: reset_n = 1'b0;
        default: ;
      endcase
      if (e <= 6)       exp_q.push_back(4'b0000);
      else if (e <= 16) exp_q.push_back({((e - 7) % 4) == 0, 1'b0, 1'b1, 1'b1});
      else if (e <= 26) exp_q.push_back(4'b0000);
      else if (e <= 30) exp_q.push_back({((e - 27) % 4) == 0, 1'b0, 1'b1, 1'b1});
      else              exp_q.push_back(4'b0000);
      cyc();
      want = exp_q.pop_front();
      obs  = {o_start, o_flag, o_fsm_rst_n, o_running};
      total++;
      if (obs !== want) begin
        bad++;
        $display("FAIL priority edge %0d: got %b want %b", e, obs, want);
      end
    end
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0;
    btn_run = 1'b0;
    btn_clr = 1'b0;
    sw_mode = 1'b0;
    test_reset();
    test_debounce();
    test_tick_cadence();
    test_pause_resume();
    test_mode_latch();
    test_priority();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
